// File: rtl/addsub_arbiter.sv
// Round-robin arbiter feeding one shared W-bit unsigned add/sub unit, one operation in flight.
// Define ADDSUB_ARB_SAT_EN to clamp overflowing adds to all-ones and borrowing subs to zero.
module addsub_arbiter #(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_carry
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW:0]   cand;
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;

  logic           op_p0;
  logic [W-1:0]   a_p0, b_p0;
  logic [IDW-1:0] id_p0;
  logic [W:0]     raw_p1;
  logic [W-1:0]   res_p1;

  // Bit W is the add carry-out, or for sub the borrow (set exactly when a < b).
  function automatic logic [W:0] addsub(input logic op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    if (op) return {1'b0, a} - {1'b0, b};
    return {1'b0, a} + {1'b0, b};
  endfunction

`ifdef ADDSUB_ARB_SAT_EN
  function automatic logic [W-1:0] sat_result(input logic op, input logic [W-1:0] raw,
                                              input logic cy);
    if (!cy) return raw;
    return op ? '0 : '1;
  endfunction
`endif

  // Round-robin search upward from ptr_q with wrap; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (rst_n && gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          state_d            = EXEC;
        end
      end
      EXEC: state_d = HOLD;
      HOLD: begin
        if (rsp_ready) begin
          state_d = IDLE;
          ptr_d   = (rsp_id == IDW'(NREQ-1)) ? '0 : rsp_id + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // p0: operands of the granted requester, captured on the handshake edge
  always_ff @(posedge clk) begin
    if (state_q == IDLE && gnt_found) begin
      op_p0 <= req_op[gnt_idx];
      a_p0  <= req_a[gnt_idx*W +: W];
      b_p0  <= req_b[gnt_idx*W +: W];
      id_p0 <= gnt_idx;
    end
  end

  // p1: arithmetic during EXEC, registered into the response on leaving EXEC
  always_comb begin
    raw_p1 = addsub(op_p0, a_p0, b_p0);
`ifdef ADDSUB_ARB_SAT_EN
    res_p1 = sat_result(op_p0, raw_p1[W-1:0], raw_p1[W]);
`else
    res_p1 = raw_p1[W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
    end else if (state_q == EXEC) begin
      rsp_data  <= res_p1;
      rsp_carry <= raw_p1[W];
      rsp_id    <= id_p0;
    end
  end

  assign rsp_valid = (state_q == HOLD);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter (NREQ=4, W=8): transaction-level model plus directed vectors.
module tb_addsub_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_carry;

  int n_vec = 0;
  int n_err = 0;

  addsub_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected result of one operation from plain unsigned arithmetic.
  task automatic model_op(input logic op, input int a, input int b, output int d, output int c);
    if (!op) begin
      d = (a + b) % (1 << W);
      c = ((a + b) >= (1 << W)) ? 1 : 0;
    end else begin
      d = (a - b + (1 << W)) % (1 << W);
      c = (a < b) ? 1 : 0;
    end
`ifdef ADDSUB_ARB_SAT_EN
    if (c == 1) d = op ? 0 : (1 << W) - 1;
`endif
  endtask

  // Transaction model: m_since = -1 when free, else cycles since the grant (capped at 2).
  int          m_since = -1;
  int          m_ptr   = 0;
  int          m_id, m_d, m_c, mj;
  logic [3:0]  exp_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_since = -1;
      m_ptr   = 0;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_rsp_carry", 32'(rsp_carry), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
    end else begin
      exp_rdy = '0;
      if (m_since < 0) begin
        for (int i = 0; i < NREQ; i++) begin
          mj = (m_ptr + i) % NREQ;
          if (exp_rdy == 0 && req_valid[mj]) exp_rdy[mj] = 1'b1;
        end
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_since == 2));
      if (m_since == 2) begin
        chk("rsp_data", 32'(rsp_data), m_d);
        chk("rsp_carry", 32'(rsp_carry), m_c);
        chk("rsp_id", 32'(rsp_id), m_id);
      end
      if (m_since < 0) begin
        if (exp_rdy != 0) begin
          for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) m_id = i;
          model_op(req_op[m_id], int'(req_a[m_id*W +: W]), int'(req_b[m_id*W +: W]), m_d, m_c);
          m_since = 1;
        end
      end else if (m_since == 1) begin
        m_since = 2;
      end else if (rsp_ready) begin
        m_since = -1;
        m_ptr   = (m_id + 1) % NREQ;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic op, input logic [7:0] a, input logic [7:0] b);
    req_op[i]       = op;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  int q_idx[$];
  int q_cyc[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_ptr_state_ready", 32'(req_ready), 0);

    // Basic add on requester 0
    rst_n = 1'b1;
    set_req(0, 1'b0, 8'h05, 8'h03);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    mid(); chk("t1_grant", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    mid(); chk("t1_not_yet_valid", 32'(rsp_valid), 0);
    tick(); mid();
    chk("t1_valid", 32'(rsp_valid), 1);
    chk("t1_data", 32'(rsp_data), 32'h08);
    chk("t1_carry", 32'(rsp_carry), 0);
    chk("t1_id", 32'(rsp_id), 0);
    tick();

    // Reset pulse so the pointer starts from requester 0 again
    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // All requesters held valid: rotation 0,1,2,3,0 every 3 cycles
    set_req(0, 1'b0, 8'h11, 8'h22);
    set_req(1, 1'b1, 8'h19, 8'h04);
    set_req(2, 1'b0, 8'h29, 8'h05);
    set_req(3, 1'b1, 8'h39, 8'h06);
    req_valid = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      mid();
      if (req_ready != '0) begin
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) q_idx.push_back(k);
        q_cyc.push_back(c);
      end
      tick();
    end
    req_valid = '0;
    chk("t2_grant_count", 32'(q_idx.size()), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < q_idx.size()) chk("t2_grant_order", 32'(q_idx[k]), 32'(exp_order[k]));
      if (k > 0 && k < q_cyc.size()) chk("t2_grant_gap", 32'(q_cyc[k] - q_cyc[k-1]), 3);
    end
    tick(); tick();

    // Requester 2 add overflow
    set_req(2, 1'b0, 8'hF0, 8'h20);
    req_valid = 4'b0100;
    mid(); chk("t3_grant", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    tick(); mid();
`ifdef ADDSUB_ARB_SAT_EN
    chk("t3_data", 32'(rsp_data), 32'hFF);
`else
    chk("t3_data", 32'(rsp_data), 32'h10);
`endif
    chk("t3_carry", 32'(rsp_carry), 1);
    chk("t3_id", 32'(rsp_id), 2);
    tick();

    // Requester 1 sub with borrow
    set_req(1, 1'b1, 8'h02, 8'h05);
    req_valid = 4'b0010;
    mid(); chk("t4_grant", 32'(req_ready), 32'h2);
    tick(); req_valid = '0;
    tick(); mid();
`ifdef ADDSUB_ARB_SAT_EN
    chk("t4_data", 32'(rsp_data), 32'h00);
`else
    chk("t4_data", 32'(rsp_data), 32'hFD);
`endif
    chk("t4_carry", 32'(rsp_carry), 1);
    chk("t4_id", 32'(rsp_id), 1);
    tick();

    // Backpressure: HOLD for 5 cycles while requester 0 waits
    set_req(3, 1'b0, 8'h40, 8'h41);
    set_req(0, 1'b1, 8'h07, 8'h09);
    req_valid = 4'b1001; rsp_ready = 1'b0;
    mid(); chk("t5_grant", 32'(req_ready), 32'h8);
    tick(); req_valid = 4'b0001;
    tick();
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("t5_hold_valid", 32'(rsp_valid), 1);
      chk("t5_hold_data", 32'(rsp_data), 32'h81);
      chk("t5_hold_id", 32'(rsp_id), 3);
      chk("t5_hold_carry", 32'(rsp_carry), 0);
      chk("t5_hold_ready", 32'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    mid(); chk("t5_release_valid", 32'(rsp_valid), 1);
    tick(); mid(); chk("t5_next_grant", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    tick(); tick();

    // Reset while holding a response
    set_req(2, 1'b0, 8'h11, 8'h22);
    req_valid = 4'b0100; rsp_ready = 1'b0;
    mid(); chk("t6_grant", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    tick(); mid();
    chk("t6_hold_valid", 32'(rsp_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rsp_valid), 0);
    chk("t6_rst_data", 32'(rsp_data), 0);
    chk("t6_rst_id", 32'(rsp_id), 0);
    req_valid = 4'b0101;
    #1 chk("t6_rst_ready", 32'(req_ready), 0);
    tick();
    tick(); rst_n = 1'b1;
    mid(); chk("t6_first_grant", 32'(req_ready), 32'h1);
    tick(); req_valid = '0; rsp_ready = 1'b1;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
